// File: rtl/acc_seq.sv
// rtl/acc_seq.sv - command-driven N-bit accumulator with carry/borrow and valid/ready result handshake
// Optional res_zero output is enabled by defining ACC_SEQ_ZERO_FLAG_EN.
module acc_seq #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_load,
  input  logic [2:0]   cmd_mode,
  input  logic [N-1:0] cmd_operand,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_cb
`ifdef ACC_SEQ_ZERO_FLAG_EN
  ,
  output logic         res_zero
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic         lat_load;
  logic [2:0]   lat_mode;
  logic [N-1:0] lat_op;
  logic [N-1:0] acc, acc_nxt;
  logic         cb, cb_nxt;
  logic [N:0]   sum, diff;
  logic         take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          take      = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arithmetic modes run one bit wider so the top bit lands in cb.
  assign sum  = {1'b0, acc} + {1'b0, lat_op} + (N+1)'(cb);
  assign diff = {1'b0, acc} + (N+1)'(cb) - {1'b0, lat_op};

  always_comb begin
    acc_nxt = acc;
    cb_nxt  = cb;
    if (lat_load) begin
      acc_nxt = lat_op;
      cb_nxt  = 1'b0;
    end else begin
      case (lat_mode)
        3'b000: {cb_nxt, acc_nxt} = sum;
        3'b001: {cb_nxt, acc_nxt} = diff;
        3'b010: acc_nxt = acc & lat_op;
        3'b011: acc_nxt = acc | lat_op;
        3'b100: acc_nxt = acc ^ lat_op;
        3'b101: acc_nxt = ~acc;
        3'b110: acc_nxt = acc + N'(1);
        3'b111: acc_nxt = acc - N'(1);
        default: acc_nxt = acc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_load <= 1'b0;
      lat_mode <= '0;
      lat_op   <= '0;
      acc      <= '0;
      cb       <= 1'b0;
    end else begin
      if (take) begin
        lat_load <= cmd_load;
        lat_mode <= cmd_mode;
        lat_op   <= cmd_operand;
      end
      if (state == EXEC) begin
        acc <= acc_nxt;
        cb  <= cb_nxt;
      end
    end
  end

  assign res_data = acc;
  assign res_cb   = cb;

`ifdef ACC_SEQ_ZERO_FLAG_EN
  assign res_zero = (acc == '0);
`endif

endmodule

// File: tb/tb_acc_seq.sv
// tb/tb_acc_seq.sv - directed table-driven testbench for acc_seq (N=3)
module tb_acc_seq;

  localparam int N = 3;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_load;
  logic [2:0]   cmd_mode;
  logic [N-1:0] cmd_operand;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_cb;
`ifdef ACC_SEQ_ZERO_FLAG_EN
  logic         res_zero;
`endif

  int tests = 0;
  int fails = 0;

  acc_seq #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_mode    (cmd_mode),
    .cmd_operand (cmd_operand),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_cb      (res_cb)
`ifdef ACC_SEQ_ZERO_FLAG_EN
    ,
    .res_zero    (res_zero)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       ld;
    logic [2:0] mode;
    logic [2:0] op;
    logic [2:0] exp_d;
    logic       exp_cb;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one command from IDLE and walk it to RESP, checking handshake timing.
  task automatic issue(input logic ld, input logic [2:0] md, input logic [2:0] op);
    @(negedge clk);
    check("idle_cmd_ready", int'(cmd_ready), 1);
    check("idle_res_valid", int'(res_valid), 0);
    cmd_valid   = 1'b1;
    cmd_load    = ld;
    cmd_mode    = md;
    cmd_operand = op;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("exec_res_valid", int'(res_valid), 0);
    check("exec_cmd_ready", int'(cmd_ready), 0);
    @(negedge clk);
    check("resp_res_valid", int'(res_valid), 1);
    check("resp_cmd_ready", int'(cmd_ready), 0);
  endtask

  task automatic release_resp();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("post_resp_valid", int'(res_valid), 0);
    check("post_resp_ready", int'(cmd_ready), 1);
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_load    = 1'b0;
    cmd_mode    = 3'd0;
    cmd_operand = '0;
    res_ready   = 1'b0;

    vecs[0]  = '{1'b1, 3'b000, 3'd5, 3'd5, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 3'd3, 3'd0, 1'b1};
    vecs[2]  = '{1'b0, 3'b000, 3'd0, 3'd1, 1'b0};
    vecs[3]  = '{1'b1, 3'b111, 3'd2, 3'd2, 1'b0};
    vecs[4]  = '{1'b0, 3'b001, 3'd3, 3'd7, 1'b1};
    vecs[5]  = '{1'b0, 3'b110, 3'd0, 3'd0, 1'b1};
    vecs[6]  = '{1'b1, 3'b000, 3'd6, 3'd6, 1'b0};
    vecs[7]  = '{1'b0, 3'b010, 3'd3, 3'd2, 1'b0};
    vecs[8]  = '{1'b0, 3'b011, 3'd1, 3'd3, 1'b0};
    vecs[9]  = '{1'b0, 3'b100, 3'd7, 3'd4, 1'b0};
    vecs[10] = '{1'b0, 3'b101, 3'd0, 3'd3, 1'b0};
    vecs[11] = '{1'b0, 3'b111, 3'd0, 3'd2, 1'b0};
    vecs[12] = '{1'b1, 3'b000, 3'd7, 3'd7, 1'b0};
    vecs[13] = '{1'b0, 3'b000, 3'd7, 3'd6, 1'b1};
    vecs[14] = '{1'b0, 3'b001, 3'd7, 3'd0, 1'b0};
    vecs[15] = '{1'b1, 3'b000, 3'd0, 3'd0, 1'b0};

    #1;
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_cb", int'(res_cb), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].ld, vecs[i].mode, vecs[i].op);
      check($sformatf("vec%0d_data", i), int'(res_data), int'(vecs[i].exp_d));
      check($sformatf("vec%0d_cb", i), int'(res_cb), int'(vecs[i].exp_cb));
      release_resp();
    end

    // 111 from zero wraps to 7 without touching cb
    issue(1'b0, 3'b111, 3'd0);
    check("wrap_dec_data", int'(res_data), 7);
    check("wrap_dec_cb", int'(res_cb), 0);
    release_resp();

    // Stall in RESP with stray command pulses that must be ignored
    issue(1'b1, 3'b000, 3'd3);
    for (int k = 0; k < 5; k++) begin
      cmd_valid   = 1'b1;
      cmd_load    = 1'b1;
      cmd_operand = 3'd6;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("stall_res_valid", int'(res_valid), 1);
      check("stall_res_data", int'(res_data), 3);
      check("stall_cmd_ready", int'(cmd_ready), 0);
    end
    release_resp();
    @(negedge clk);
    check("stall_acc_kept", int'(res_data), 3);
    check("stall_no_extra", int'(res_valid), 0);

    // Reset while the load of 5 is in EXEC
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_load    = 1'b1;
    cmd_operand = 3'd5;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_valid", int'(res_valid), 0);
    check("mid_rst_data", int'(res_data), 0);
    check("mid_rst_cb", int'(res_cb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_cmd_ready", int'(cmd_ready), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_valid", int'(res_valid), 0);
      check("no_stale_data", int'(res_data), 0);
    end
    issue(1'b0, 3'b110, 3'd0);
    check("post_rst_inc", int'(res_data), 1);
    check("post_rst_cb", int'(res_cb), 0);
    release_resp();

`ifdef ACC_SEQ_ZERO_FLAG_EN
    issue(1'b1, 3'b000, 3'd7);
    check("zf_load_zero", int'(res_zero), 0);
    release_resp();
    issue(1'b0, 3'b110, 3'd0);
    check("zf_data", int'(res_data), 0);
    check("zf_zero", int'(res_zero), 1);
    check("zf_cb", int'(res_cb), 0);
    release_resp();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
